seq_mult_ctrl: RTL and testbench
================================

# seq_mult_ctrl

Handshake front-end and accumulator for the 8x8 sequential shift-add multiplier. Accepts operand pairs on a valid/ready input channel, sequences the multiplier's `enable` (load, then run), and captures the 16-bit product after a fixed latency. Optionally adds the product into a running accumulator, which makes dot products possible. Presents the result on a valid/ready output channel. It sits directly upstream of the multiplier and drives its A, B and enable inputs; it also consumes the multiplier's C output.

## Interface
- `MUL_LAT`, 9: number of rising edges with enable high, after a load edge, until `mul_c` holds the full product
- `ACC_W`, 24: accumulator and result width (must be ≥16)
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept (high only in IDLE)
- `in_a`, `in_b`  in  8 each  unsigned operands
- `in_acc`  in  1  0: result = product; 1: result = previous accumulator + product
- `mul_enable`  out  1  multiplier enable (low = load/clear)
- `mul_a`, `mul_b`  out  8 each  registered operands to the multiplier
- `mul_c`  in  16  multiplier product
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  ACC_W  result / accumulator value
- `out_ovf`  out  1  carry out of the accumulate for this result

## Operation
- FSM states are IDLE, LOAD, RUN and DONE. Reset state is IDLE.
- IDLE: `in_ready`=1, `mul_enable`=0.
  - On `in_valid`&`in_ready`: latch `in_a`→`mul_a`, `in_b`→`mul_b` and `in_acc`→`acc_sel`, then go to LOAD.
- LOAD: one cycle.
  - `mul_enable`=0, so the multiplier loads `mul_b` and clears at the next edge.
  - At that edge, zero the run counter, set `mul_enable`=1 and go to RUN.
- RUN: `mul_enable`=1; the run counter increments on every edge.
  - At the edge where counter==MUL_LAT, capture the result into `acc`/`out_data`, set `out_valid`=1 and `mul_enable`=0, and go to DONE.
- Result rule:
  - `acc_sel`=0: acc = zero-extended `mul_c`, `out_ovf`=0.
  - `acc_sel`=1: {`out_ovf`, acc} = acc + `mul_c`, with the sum wrapping modulo 2^ACC_W.
- DONE: `out_valid`=1; `out_data` and `out_ovf` are held stable.
  - On `out_ready`, go to IDLE and drop `out_valid`.
  - `acc` is retained for the next accumulate operation.
- `mul_a`/`mul_b` are stable from the accept edge until the operation leaves DONE; the multiplier reads A combinationally during RUN.
- `in_valid` outside IDLE is ignored; it is neither latched nor counted.
- All widths are unsigned. No saturation.

## Timing
- Reset (asynchronous assert):
  - `mul_enable`=0, `mul_a`=`mul_b`=0, `out_valid`=0, `out_data`=0, `out_ovf`=0, acc=0.
  - State goes to IDLE. `in_ready` reads 1, but no accept can occur while `reset_n` is low.
- Reset mid-operation aborts immediately: the result and the accumulator are lost, and the multiplier is held in load.
- Accept at edge T. LOAD runs in cycle T..T+1, and the load edge is T+1. Enable-high edges are T+2 through T+10. `out_valid` rises after edge T+11, so latency is 11 cycles.
- With `out_ready` held high, the output handshake occurs at T+12 and `in_ready` is high from T+12. The next accept is at T+13, so the period is 13 cycles per operation.
- `in_ready` is a combinational decode of state==IDLE. All other outputs are registered.
- Back-to-back `in_acc`=1 operations accumulate across any idle gap. An `in_acc`=0 operation restarts the sum.

## Test plan
- Reset, then 3×5 with `in_acc`=0 and `out_ready`=1 → `out_valid` 11 cycles after accept; `out_data`=15, `out_ovf`=0. `mul_enable` is low for exactly one cycle (LOAD) and high for 10 cycles.
- 255×255 with `in_acc`=0 → `out_data`=0xFE01. Then 0×200 with `in_acc`=1 → `out_data`=0xFE01.
- Dot product: 12×10 with `in_acc`=0 (→120), then 7×8 with `in_acc`=1 → `out_data`=176; then 1×1 with `in_acc`=0 → 1.
- ACC_W=16: 255×255 with `in_acc`=0, then 255×255 with `in_acc`=1 → `out_data`=0xFC02, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE while driving `in_valid`=1 with new operands → `out_data` stable, `in_ready`=0, nothing accepted. On `out_ready` the next accept occurs one cycle after the handshake.
- Pull `reset_n` low at cycle 5 of RUN → all outputs go to reset values at once. After release, 2×3 with `in_acc`=1 → `out_data`=6, because acc was cleared.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Handshake front-end and accumulator for the 8x8 sequential shift-add multiplier.
// Sequences load/run on the multiplier and presents the (optionally accumulated) product.
module seq_mult_ctrl #(
    parameter int unsigned MUL_LAT = 9,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_acc,
    output logic             mul_enable,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    localparam int unsigned         CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MUL_LAT);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               acc_sel_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic               en_q;
    logic               valid_q;
    logic [7:0]         a_q;
    logic [7:0]         b_q;
    logic [ACC_W:0]     acc_sum_d;

    // The extra top bit of the sum is the carry reported as out_ovf.
    always_comb begin
        acc_sum_d = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, mul_c};
    end

    // NOTE: every register here uses non-blocking assignment so each one samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_sel_q <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        acc_sel_q <= in_acc;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    en_q    <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        if (acc_sel_q) begin
                            {ovf_q, acc_q} <= acc_sum_d;
                        end else begin
                            acc_q <= ACC_W'(mul_c);
                            ovf_q <= 1'b0;
                        end
                        valid_q <= 1'b1;
                        en_q    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mul_enable = en_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign out_valid  = valid_q;
    assign out_data   = acc_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: a 24-bit and a 16-bit accumulator instance run in lockstep
// against a behavioural multiplier and an arithmetic reference accumulator.
module tb_seq_mult_ctrl;

    localparam int MUL_LAT = 9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_acc, out_ready;
    logic [7:0]  in_a, in_b;

    logic        in_ready, mul_enable, out_valid, out_ovf;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_c;
    logic [23:0] out_data;

    logic        in_ready16, mul_enable16, out_valid16, out_ovf16;
    logic [7:0]  mul_a16, mul_b16;
    logic [15:0] mul_c16;
    logic [15:0] out_data16;

    int  n_checks = 0;
    int  n_fail   = 0;
    time accept_t = 0;
    time hs_t     = 0;

    longint acc24_m = 0;
    longint acc16_m = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.MUL_LAT(MUL_LAT), .ACC_W(24)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .mul_enable(mul_enable),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    seq_mult_ctrl #(.MUL_LAT(MUL_LAT), .ACC_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .mul_enable(mul_enable16),
        .mul_a(mul_a16), .mul_b(mul_b16), .mul_c(mul_c16), .out_valid(out_valid16),
        .out_ready(out_ready), .out_data(out_data16), .out_ovf(out_ovf16)
    );

    // Multiplier stand-ins: the product is only correct after exactly MUL_LAT enabled edges.
    logic [7:0] mb_q = '0, mb16_q = '0;
    int         step = 0, step16 = 0;
    logic [15:0] prod, prod16;
    assign prod    = {8'b0, mul_a} * {8'b0, mb_q};
    assign prod16  = {8'b0, mul_a16} * {8'b0, mb16_q};
    assign mul_c   = (step == MUL_LAT) ? prod : prod ^ 16'h5A5A;
    assign mul_c16 = (step16 == MUL_LAT) ? prod16 : prod16 ^ 16'h5A5A;

    always @(posedge clk) begin
        if (!mul_enable) begin mb_q <= mul_b; step <= 0; end
        else step <= step + 1;
        if (!mul_enable16) begin mb16_q <= mul_b16; step16 <= 0; end
        else step16 <= step16 + 1;
    end

    task automatic ref_op(input int a, input int b, input bit accf,
                          output logic [23:0] e24, output logic o24,
                          output logic [15:0] e16, output logic o16);
        longint p, s24, s16;
        p = longint'(a) * longint'(b);
        s24 = accf ? acc24_m + p : p;
        s16 = accf ? acc16_m + p : p;
        e24 = 24'(s24 % (64'd1 << 24));
        o24 = (s24 >= (64'd1 << 24));
        e16 = 16'(s16 % (64'd1 << 16));
        o16 = (s16 >= (64'd1 << 16));
        acc24_m = longint'(e24);
        acc16_m = longint'(e16);
    endtask

    // Starts at a falling edge, ends at the falling edge after the output handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit accf, input int hold,
                         output logic [23:0] g24, output logic go24,
                         output logic [15:0] g16, output logic go16);
        logic [23:0] e24; logic [15:0] e16; logic o24, o16;
        int w, k, hi, lo;
        ref_op(int'(a), int'(b), accf, e24, o24, e16, o16);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_a = a; in_b = b; in_acc = accf; out_ready = 1'b0;
        @(negedge clk);
        accept_t = $time;
        k = 0; hi = 0; lo = 0;
        while (!out_valid && k < 30) begin
            if (mul_enable) hi++; else lo++;
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'($urandom);
            @(negedge clk); k++;
        end
        n_checks++; if (k != 11) begin n_fail++; $display("FAIL latency got=%0d exp=11", k); end
        n_checks++; if (hi != 10 || lo != 1) begin n_fail++; $display("FAIL enable_profile high=%0d low=%0d exp 10/1", hi, lo); end
        n_checks++; if (out_data !== e24 || out_ovf !== o24) begin n_fail++; $display("FAIL result24 got=%h/%b exp=%h/%b", out_data, out_ovf, e24, o24); end
        n_checks++; if (out_valid16 !== 1'b1 || out_data16 !== e16 || out_ovf16 !== o16) begin n_fail++; $display("FAIL result16 got=%b %h/%b exp=1 %h/%b", out_valid16, out_data16, out_ovf16, e16, o16); end
        n_checks++; if (mul_a !== a || mul_b !== b) begin n_fail++; $display("FAIL operands_held got=%h,%h exp=%h,%h", mul_a, mul_b, a, b); end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e24 || mul_a !== a || mul_b !== b) begin
                n_fail++; $display("FAIL backpressure_hold v=%b r=%b d=%h a=%h b=%h exp 1 0 %h %h %h", out_valid, in_ready, out_data, mul_a, mul_b, e24, a, b);
            end
        end
        g24 = out_data; go24 = out_ovf; g16 = out_data16; go16 = out_ovf16;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        hs_t = $time;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL handshake got v=%b r=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (in_ready !== 1'b1 || mul_enable !== 1'b0 || mul_a !== 8'h00 || mul_b !== 8'h00 ||
            out_valid !== 1'b0 || out_data !== 24'h0 || out_ovf !== 1'b0 ||
            mul_enable16 !== 1'b0 || out_valid16 !== 1'b0 || out_data16 !== 16'h0) begin
            n_fail++;
            $display("FAIL %s got rdy=%b en=%b a=%h b=%h v=%b d=%h o=%b en16=%b v16=%b d16=%h exp 1 0 00 00 0 0 0 0 0 0",
                     tag, in_ready, mul_enable, mul_a, mul_b, out_valid, out_data, out_ovf, mul_enable16, out_valid16, out_data16);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; in_a = 8'hAB; in_b = 8'hCD; in_acc = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        in_valid = 1'b0;
        reset_n = 1'b1;
        acc24_m = 0; acc16_m = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        do_op(8'd3, 8'd5, 1'b0, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'd15 || o !== 1'b0) begin n_fail++; $display("FAIL basic_3x5 got=%0d/%b exp=15/0", g, o); end
    endtask

    task automatic test_zero_operand();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        do_op(8'd255, 8'd255, 1'b0, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'hFE01) begin n_fail++; $display("FAIL max_product got=%h exp=fe01", g); end
        do_op(8'd0, 8'd200, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'hFE01 || o !== 1'b0) begin n_fail++; $display("FAIL zero_acc got=%h/%b exp=fe01/0", g, o); end
    endtask

    task automatic test_dot_product();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        do_op(8'd12, 8'd10, 1'b0, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'd120) begin n_fail++; $display("FAIL dot_first got=%0d exp=120", g); end
        do_op(8'd7, 8'd8, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'd176) begin n_fail++; $display("FAIL dot_sum got=%0d exp=176", g); end
        do_op(8'd1, 8'd1, 1'b0, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'd1) begin n_fail++; $display("FAIL dot_restart got=%0d exp=1", g); end
    endtask

    task automatic test_wrap16();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        do_op(8'd255, 8'd255, 1'b0, 0, g, o, g16, o16);
        do_op(8'd255, 8'd255, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (g16 !== 16'hFC02 || o16 !== 1'b1) begin n_fail++; $display("FAIL wrap16 got=%h/%b exp=fc02/1", g16, o16); end
        n_checks++; if (g !== 24'h1FC02 || o !== 1'b0) begin n_fail++; $display("FAIL nowrap24 got=%h/%b exp=1fc02/0", g, o); end
    endtask

    task automatic test_backpressure();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        time hs;
        do_op(8'd9, 8'd11, 1'b0, 20, g, o, g16, o16);
        n_checks++; if (g !== 24'd99) begin n_fail++; $display("FAIL bp_result got=%0d exp=99", g); end
        hs = hs_t;
        do_op(8'd4, 8'd6, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (accept_t - hs != 10) begin n_fail++; $display("FAIL bp_next_accept got=%0t exp=10", accept_t - hs); end
        n_checks++; if (g !== 24'd123) begin n_fail++; $display("FAIL bp_accumulate got=%0d exp=123", g); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        time t1;
        do_op(8'd21, 8'd2, 1'b0, 0, g, o, g16, o16);
        t1 = accept_t;
        do_op(8'd5, 8'd5, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (accept_t - t1 != 130) begin n_fail++; $display("FAIL period got=%0t exp=130", accept_t - t1); end
        n_checks++; if (g !== 24'd67) begin n_fail++; $display("FAIL b2b_sum got=%0d exp=67", g); end
    endtask

    task automatic test_mid_run_reset();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        do_op(8'd100, 8'd100, 1'b0, 0, g, o, g16, o16);
        in_valid = 1'b1; in_a = 8'd77; in_b = 8'd88; in_acc = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (mul_enable !== 1'b1) begin n_fail++; $display("FAIL in_run got en=%b exp=1", mul_enable); end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66;
        @(negedge clk);
        check_reset_outputs("held_in_reset");
        in_valid = 1'b0;
        reset_n = 1'b1;
        acc24_m = 0; acc16_m = 0;
        @(negedge clk);
        do_op(8'd2, 8'd3, 1'b1, 0, g, o, g16, o16);
        n_checks++; if (g !== 24'd6 || g16 !== 16'd6) begin n_fail++; $display("FAIL post_reset_acc got=%0d,%0d exp=6", g, g16); end
    endtask

    task automatic test_random();
        logic [23:0] g; logic o, o16; logic [15:0] g16;
        for (int i = 0; i < 25; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), g, o, g16, o16);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_operand();
        test_dot_product();
        test_wrap16();
        test_backpressure();
        test_back_to_back();
        test_mid_run_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
